// File: rtl/pipe_ma_pkg.sv
// pipe_ma_pkg: shared encodings for the memory-access pipeline stage.
//   rw_e_t     - access kind (none / store / signed load / unsigned load)
//   rw_len_t   - access size (byte / half / word / double)
//   ma_state_t - control FSM states
//   ma_misaligned() - natural-alignment test on the low address bits
package pipe_ma_pkg;

  typedef enum logic [1:0] {
    RW_NONE   = 2'b00,
    RW_STORE  = 2'b01,
    RW_LOAD_S = 2'b10,
    RW_LOAD_U = 2'b11
  } rw_e_t;

  typedef enum logic [1:0] {
    LEN_B = 2'b00,
    LEN_H = 2'b01,
    LEN_W = 2'b10,
    LEN_D = 2'b11
  } rw_len_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OUT
  } ma_state_t;

  // True when the address is not a multiple of the access size.
  function automatic logic ma_misaligned(input logic [1:0] len, input logic [2:0] lo);
    logic r;
    case (rw_len_t'(len))
      LEN_B:   r = 1'b0;
      LEN_H:   r = lo[0];
      LEN_W:   r = |lo[1:0];
      default: r = |lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ma_lane_align.sv
// ma_lane_align: combinational lane steering for the MA stage.
//   Store side: st_len_i/st_off_i/st_din_i -> st_wdata_o (shifted, size-masked
//               data) and st_be_o (byte enables).
//   Load side:  ld_len_i/ld_off_i/ld_rdata_i/ld_signed_i -> ld_val_o
//               (extracted, sign- or zero-extended to DATA_L).
module ma_lane_align
  import pipe_ma_pkg::*;
#(
  parameter  int unsigned DATA_L = 64,
  localparam int unsigned NB     = DATA_L / 8,
  localparam int unsigned OFF_W  = $clog2(DATA_L / 8)
) (
  input  logic [1:0]        st_len_i,
  input  logic [OFF_W-1:0]  st_off_i,
  input  logic [DATA_L-1:0] st_din_i,
  output logic [DATA_L-1:0] st_wdata_o,
  output logic [NB-1:0]     st_be_o,
  input  logic [1:0]        ld_len_i,
  input  logic              ld_signed_i,
  input  logic [OFF_W-1:0]  ld_off_i,
  input  logic [DATA_L-1:0] ld_rdata_i,
  output logic [DATA_L-1:0] ld_val_o
);

  // Low (8 << len) bits set. A shift by >= DATA_L yields zero, so a full-width
  // access naturally produces an all-ones mask.
  function automatic logic [DATA_L-1:0] bit_mask(input logic [1:0] len);
    logic [DATA_L-1:0] ones;
    ones = '1;
    return ~(ones << (7'd8 << len));
  endfunction

  function automatic logic [NB-1:0] byte_mask(input logic [1:0] len);
    logic [NB-1:0] ones;
    ones = '1;
    return ~(ones << (4'd1 << len));
  endfunction

  logic [DATA_L-1:0] ld_mask;
  logic [DATA_L-1:0] ld_raw;
  logic              ld_sign;

  always_comb begin
    st_be_o    = byte_mask(st_len_i) << st_off_i;
    st_wdata_o = (st_din_i & bit_mask(st_len_i)) << {st_off_i, 3'b000};
  end

  always_comb begin
    ld_mask  = bit_mask(ld_len_i);
    ld_raw   = (ld_rdata_i >> {ld_off_i, 3'b000}) & ld_mask;
    // mask ^ (mask >> 1) isolates the top bit of the contiguous mask.
    ld_sign  = |(ld_raw & (ld_mask ^ (ld_mask >> 1)));
    ld_val_o = ld_signed_i ? (ld_raw | (~ld_mask & {DATA_L{ld_sign}})) : ld_raw;
  end

endmodule

// File: rtl/pipe_ma_ctrl.sv
// pipe_ma_ctrl: memory-access pipeline stage between EX and WB.
//   in_*   - EX result handshake (valid/ready), access kind/size, address,
//            store data, writeback enable and destination index.
//   mem_*  - request/grant/response memory port; address aligned to DATA_L/8,
//            lane-shifted write data and byte enables.
//   out_*  - WB result handshake, writeback value, misaligned/illegal flag.
//   fwd_*  - MA forwarding path (fwd_idx = 0 when nothing is forwarded).
//   clk, rst - clock and synchronous active-low reset.
module pipe_ma_ctrl
  import pipe_ma_pkg::*;
#(
  parameter int unsigned DATA_L  = 64,
  parameter int unsigned MADDR_L = 32,
  parameter int unsigned IDX_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_rw_e,
  input  logic [1:0]          in_rw_len,
  input  logic [MADDR_L-1:0]  in_addr,
  input  logic [DATA_L-1:0]   in_din,
  input  logic                in_wb_e,
  input  logic [IDX_W-1:0]    in_wb_idx,
  output logic                mem_req,
  output logic                mem_we,
  output logic [MADDR_L-1:0]  mem_addr,
  output logic [DATA_L-1:0]   mem_wdata,
  output logic [DATA_L/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_L-1:0]   mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_wb_e,
  output logic [IDX_W-1:0]    out_wb_idx,
  output logic [DATA_L-1:0]   out_wb_val,
  output logic                out_exc,
  output logic [IDX_W-1:0]    fwd_idx,
  output logic [DATA_L-1:0]   fwd_val
);

  localparam int unsigned NB    = DATA_L / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  ma_state_t          state_q;
  logic [1:0]         len_q;
  logic [OFF_W-1:0]   off_q;
  logic               ld_signed_q;
  logic               wbe_q;

  logic               mem_req_q;
  logic               mem_we_q;
  logic [MADDR_L-1:0] mem_addr_q;
  logic [DATA_L-1:0]  mem_wdata_q;
  logic [NB-1:0]      mem_be_q;

  logic               out_valid_q;
  logic               out_wb_e_q;
  logic [IDX_W-1:0]   out_wb_idx_q;
  logic [DATA_L-1:0]  out_wb_val_q;
  logic               out_exc_q;

  logic               accept;
  logic               in_bad;
  logic               in_wbe;
  logic [OFF_W-1:0]   in_off;
  logic [MADDR_L-1:0] in_maddr;
  logic [DATA_L-1:0]  st_wdata;
  logic [NB-1:0]      st_be;
  logic [DATA_L-1:0]  ld_val;

  always_comb begin
    in_ready = rst & ((state_q == ST_IDLE) | ((state_q == ST_OUT) & out_ready));
    accept   = in_valid & in_ready;
    in_off   = in_addr[OFF_W-1:0];
    in_maddr = in_addr & ~(MADDR_L'(NB - 1));
    in_wbe   = in_wb_e & (in_wb_idx != '0);
    in_bad   = ma_misaligned(in_rw_len, in_addr[2:0]) |
               ((in_rw_len == LEN_D) & (DATA_L == 32));
  end

  // Store lanes come straight from the EX inputs (captured at accept);
  // load lanes use the latched access description against mem_rdata.
  ma_lane_align #(
    .DATA_L (DATA_L)
  ) u_lane (
    .st_len_i    (in_rw_len),
    .st_off_i    (in_off),
    .st_din_i    (in_din),
    .st_wdata_o  (st_wdata),
    .st_be_o     (st_be),
    .ld_len_i    (len_q),
    .ld_signed_i (ld_signed_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (mem_rdata),
    .ld_val_o    (ld_val)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      off_q        <= '0;
      ld_signed_q  <= 1'b0;
      wbe_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      out_valid_q  <= 1'b0;
      out_wb_e_q   <= 1'b0;
      out_wb_idx_q <= '0;
      out_wb_val_q <= '0;
      out_exc_q    <= 1'b0;
    end else if (accept) begin
      // Accept from IDLE and back-to-back accept from OUT share this path.
      len_q        <= in_rw_len;
      off_q        <= in_off;
      ld_signed_q  <= (in_rw_e == RW_LOAD_S);
      wbe_q        <= in_wbe;
      out_wb_idx_q <= in_wb_idx;
      out_exc_q    <= 1'b0;
      if (in_rw_e == RW_NONE) begin
        state_q      <= ST_OUT;
        out_valid_q  <= 1'b1;
        out_wb_e_q   <= in_wbe;
        out_wb_val_q <= DATA_L'(in_addr);
      end else if (in_bad) begin
        state_q      <= ST_OUT;
        out_valid_q  <= 1'b1;
        out_wb_e_q   <= 1'b0;
        out_wb_val_q <= '0;
        out_exc_q    <= 1'b1;
      end else begin
        state_q      <= ST_REQ;
        out_valid_q  <= 1'b0;
        out_wb_e_q   <= 1'b0;
        mem_req_q    <= 1'b1;
        mem_we_q     <= (in_rw_e == RW_STORE);
        mem_addr_q   <= in_maddr;
        mem_wdata_q  <= st_wdata;
        mem_be_q     <= st_be;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              state_q      <= ST_OUT;
              out_valid_q  <= 1'b1;
              out_wb_e_q   <= 1'b0;
              out_wb_val_q <= '0;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state_q      <= ST_OUT;
            out_valid_q  <= 1'b1;
            out_wb_e_q   <= wbe_q;
            out_wb_val_q <= ld_val;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req    = mem_req_q;
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    mem_be     = mem_be_q;
    out_valid  = out_valid_q;
    out_wb_e   = out_wb_e_q;
    out_wb_idx = out_wb_idx_q;
    out_wb_val = out_wb_val_q;
    out_exc    = out_exc_q;
    fwd_idx    = (out_valid_q & out_wb_e_q) ? out_wb_idx_q : '0;
    fwd_val    = out_wb_val_q;
  end

endmodule

// File: tb/tb_pipe_ma_ctrl.sv
// tb_pipe_ma_ctrl: directed, table-driven bench for pipe_ma_ctrl (DATA_L=64).
module tb_pipe_ma_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_rw_e;
  logic [1:0]  in_rw_len;
  logic [31:0] in_addr;
  logic [63:0] in_din;
  logic        in_wb_e;
  logic [4:0]  in_wb_idx;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic        out_wb_e;
  logic [4:0]  out_wb_idx;
  logic [63:0] out_wb_val;
  logic        out_exc;
  logic [4:0]  fwd_idx;
  logic [63:0] fwd_val;

  pipe_ma_ctrl #(
    .DATA_L  (64),
    .MADDR_L (32),
    .IDX_W   (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rw_e    (in_rw_e),
    .in_rw_len  (in_rw_len),
    .in_addr    (in_addr),
    .in_din     (in_din),
    .in_wb_e    (in_wb_e),
    .in_wb_idx  (in_wb_idx),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_wb_e   (out_wb_e),
    .out_wb_idx (out_wb_idx),
    .out_wb_val (out_wb_val),
    .out_exc    (out_exc),
    .fwd_idx    (fwd_idx),
    .fwd_val    (fwd_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  rw_e;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [63:0] din;
    logic        wb_e;
    logic [4:0]  idx;
    logic [63:0] rdata;
    logic        exp_req;
    logic [31:0] exp_maddr;
    logic [7:0]  exp_be;
    logic [63:0] exp_wdata;
    logic        exp_exc;
    logic        exp_wbe;
    logic        chk_val;
    logic [63:0] exp_val;
  } vec_t;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_rw_e    = 2'b00;
    in_rw_len  = 2'b00;
    in_addr    = '0;
    in_din     = '0;
    in_wb_e    = 1'b0;
    in_wb_idx  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    out_ready  = 1'b0;
  endtask

  task automatic drive_op(input logic [1:0] rw_e, input logic [1:0] len, input logic [31:0] addr,
                          input logic [63:0] din, input logic wb_e, input logic [4:0] idx);
    in_valid  = 1'b1;
    in_rw_e   = rw_e;
    in_rw_len = len;
    in_addr   = addr;
    in_din    = din;
    in_wb_e   = wb_e;
    in_wb_idx = idx;
  endtask

  // Issue one op from IDLE, service the memory port with immediate grant,
  // check the result, then release it with out_ready.
  task automatic run_vec(input int id, input vec_t v);
    bit saw_req;
    int n;
    string tag;
    tag = $sformatf("v%0d", id);
    saw_req = 1'b0;
    n = 0;
    @(negedge clk);
    drive_op(v.rw_e, v.len, v.addr, v.din, v.wb_e, v.idx);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      if (mem_req && !saw_req) begin
        saw_req = 1'b1;
        chk({tag, "_mem_addr"}, mem_addr, v.exp_maddr);
        chk({tag, "_mem_be"}, mem_be, v.exp_be);
        chk({tag, "_mem_wdata"}, mem_wdata, v.exp_wdata);
        chk({tag, "_mem_we"}, mem_we, v.rw_e == 2'b01);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        if (v.rw_e[1]) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.rdata;
          @(negedge clk);
          mem_rvalid = 1'b0;
          mem_rdata  = '0;
        end
      end else begin
        @(negedge clk);
      end
      n++;
    end
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_req_issued"}, saw_req, v.exp_req);
    if (!v.exp_req) chk({tag, "_latency"}, n, 0);
    chk({tag, "_out_exc"}, out_exc, v.exp_exc);
    chk({tag, "_out_wb_e"}, out_wb_e, v.exp_wbe);
    chk({tag, "_out_wb_idx"}, out_wb_idx, v.idx);
    chk({tag, "_fwd_idx"}, fwd_idx, v.exp_wbe ? v.idx : 5'd0);
    if (v.chk_val) chk({tag, "_out_wb_val"}, out_wb_val, v.exp_val);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, out_valid, 1'b0);
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{2'b10, 2'b00, 32'h1003, 64'h0, 1'b1, 5'd1, 64'h0000_0000_8000_0000,
                 1'b1, 32'h1000, 8'h08, 64'h0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{2'b11, 2'b00, 32'h1003, 64'h0, 1'b1, 5'd1, 64'h0000_0000_8000_0000,
                 1'b1, 32'h1000, 8'h08, 64'h0, 1'b0, 1'b1, 1'b1, 64'h80};
    vecs[2]  = '{2'b01, 2'b01, 32'h1006, 64'h1234, 1'b1, 5'd5, 64'h0,
                 1'b1, 32'h1000, 8'hC0, 64'h1234_0000_0000_0000, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[3]  = '{2'b10, 2'b10, 32'h1002, 64'h0, 1'b1, 5'd6, 64'h0,
                 1'b0, 32'h0, 8'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[4]  = '{2'b00, 2'b00, 32'h55, 64'h0, 1'b1, 5'd3, 64'h0,
                 1'b0, 32'h0, 8'h0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h55};
    vecs[5]  = '{2'b10, 2'b01, 32'h1002, 64'h0, 1'b1, 5'd7, 64'h1111_2222_F00D_3333,
                 1'b1, 32'h1000, 8'h0C, 64'h0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_F00D};
    vecs[6]  = '{2'b11, 2'b10, 32'h1004, 64'h0, 1'b1, 5'd8, 64'h8765_4321_0000_0000,
                 1'b1, 32'h1000, 8'hF0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h8765_4321};
    vecs[7]  = '{2'b10, 2'b11, 32'h2008, 64'h0, 1'b1, 5'd9, 64'hDEAD_BEEF_0123_4567,
                 1'b1, 32'h2008, 8'hFF, 64'h0, 1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567};
    vecs[8]  = '{2'b01, 2'b00, 32'h1001, 64'hABCD, 1'b0, 5'd0, 64'h0,
                 1'b1, 32'h1000, 8'h02, 64'hCD00, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[9]  = '{2'b01, 2'b10, 32'h1004, 64'hFFFF_FFFF_1234_5678, 1'b1, 5'd10, 64'h0,
                 1'b1, 32'h1000, 8'hF0, 64'h1234_5678_0000_0000, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[10] = '{2'b10, 2'b11, 32'h1004, 64'h0, 1'b1, 5'd11, 64'h0,
                 1'b0, 32'h0, 8'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[11] = '{2'b11, 2'b00, 32'h3000, 64'h0, 1'b1, 5'd0, 64'h7F,
                 1'b1, 32'h3000, 8'h01, 64'h0, 1'b0, 1'b0, 1'b1, 64'h7F};
    vecs[12] = '{2'b11, 2'b01, 32'h1001, 64'h0, 1'b1, 5'd12, 64'h0,
                 1'b0, 32'h0, 8'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[13] = '{2'b00, 2'b00, 32'hABC, 64'h0, 1'b0, 5'd7, 64'h0,
                 1'b0, 32'h0, 8'h0, 64'h0, 1'b0, 1'b0, 1'b1, 64'hABC};
    vecs[14] = '{2'b10, 2'b10, 32'h100C, 64'h0, 1'b1, 5'd13, 64'h8000_0001_0000_0000,
                 1'b1, 32'h1008, 8'hF0, 64'h0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0001};

    idle_inputs();
    rst = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_fwd_idx", fwd_idx, 5'd0);
    chk("rst_wb_val", out_wb_val, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // OUT stall for 3 cycles, then back-to-back accept on release
    @(negedge clk);
    drive_op(2'b00, 2'b00, 32'h55, 64'h0, 1'b1, 5'd3);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_wb_val", out_wb_val, 64'h55);
      chk("stall_fwd_idx", fwd_idx, 5'd3);
      chk("stall_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drive_op(2'b00, 2'b00, 32'h66, 64'h0, 1'b1, 5'd4);
    #1;
    chk("b2b_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_out_valid", out_valid, 1'b1);
    chk("b2b_wb_val", out_wb_val, 64'h66);
    chk("b2b_fwd_idx", fwd_idx, 5'd4);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_done", out_valid, 1'b0);

    // Store with grant delayed two cycles: request held stable
    @(negedge clk);
    drive_op(2'b01, 2'b10, 32'h2004, 64'hCAFE_BABE, 1'b1, 5'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("hold_mem_req", mem_req, 1'b1);
      chk("hold_mem_addr", mem_addr, 32'h2000);
      chk("hold_mem_be", mem_be, 8'hF0);
      chk("hold_mem_wdata", mem_wdata, 64'hCAFE_BABE_0000_0000);
      @(negedge clk);
    end
    chk("hold_no_out", out_valid, 1'b0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("st_req_drop", mem_req, 1'b0);
    chk("st_out_valid", out_valid, 1'b1);
    chk("st_out_wb_e", out_wb_e, 1'b0);
    chk("st_fwd_idx", fwd_idx, 5'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while waiting for load data; late rvalid must be ignored
    @(negedge clk);
    drive_op(2'b11, 2'b00, 32'h1000, 64'h0, 1'b1, 5'd2);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rw_req", mem_req, 1'b1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rw_rst_in_ready", in_ready, 1'b0);
    chk("rw_rst_out_valid", out_valid, 1'b0);
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h55;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    chk("rw_out_valid", out_valid, 1'b0);
    chk("rw_in_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("rw_out_valid2", out_valid, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
